// File: rtl/alu_nibble_sequencer.sv
// Sequences 8-bit add/subtract/logic operations through an external 4-bit ALU.
// Each operation runs as a low-nibble pass, then a high-nibble pass, with the carry held in a register between them.
module alu_nibble_sequencer #(
    parameter logic [4:0] SEL_ADD        = 5'b00000,
    parameter logic [4:0] SEL_SUB        = 5'b00001,
    parameter logic [4:0] SEL_LOGIC_BASE = 5'b10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    input  logic [2:0]  op,
    input  logic        cin,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_carry,
    output logic [4:0]  alu_s,
    input  logic [3:0]  alu_y,
    input  logic        alu_cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  result,
    output logic        res_cout,
    output logic        res_zero,
    output logic        res_ovf,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [2:0]  op_r;
    logic        cin_r;
    logic        carry_r;
    logic        is_logic_s;
    logic        is_sub_s;
    logic        use_cin_s;
    logic [4:0]  sel_s;
    logic        ovf_s;

    // Opcode decode: op[2] selects logic, op[1] subtract, op[0] uses the supplied carry.
    always_comb begin
        is_logic_s = op_r[2];
        is_sub_s   = ~op_r[2] & op_r[1];
        use_cin_s  = ~op_r[2] & op_r[0];
        if (is_logic_s) begin
            sel_s = {SEL_LOGIC_BASE[4], op_r[1:0], SEL_LOGIC_BASE[1:0]};
        end else if (is_sub_s) begin
            sel_s = SEL_SUB;
        end else begin
            sel_s = SEL_ADD;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next_s = state_r;
        start_ready  = 1'b0;
        res_valid    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next_s = ST_LO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LO: begin
                state_next_s = ST_HI;
            end
            ST_HI: begin
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // ALU drive; held at zero whenever no pass is in flight.
    always_comb begin
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_carry = 1'b0;
        alu_s     = 5'b00000;
        case (state_r)
            ST_LO: begin
                alu_a = a_r[3:0];
                alu_b = b_r[3:0];
                alu_s = sel_s;
                if (is_logic_s) begin
                    alu_carry = 1'b0;
                end else if (use_cin_s) begin
                    alu_carry = cin_r;
                end else begin
                    alu_carry = is_sub_s;
                end
            end
            ST_HI: begin
                alu_a = a_r[7:4];
                alu_b = b_r[7:4];
                alu_s = sel_s;
                if (is_logic_s) begin
                    alu_carry = 1'b0;
                end else begin
                    alu_carry = carry_r;
                end
            end
            default: begin
                alu_a     = 4'h0;
                alu_b     = 4'h0;
                alu_carry = 1'b0;
                alu_s     = 5'b00000;
            end
        endcase
    end

    // Signed overflow from operand sign bits and the high-nibble result sign.
    always_comb begin
        if (is_logic_s) begin
            ovf_s = 1'b0;
        end else if (is_sub_s) begin
            ovf_s = (a_r[7] != b_r[7]) && (alu_y[3] != a_r[7]);
        end else begin
            ovf_s = (a_r[7] == b_r[7]) && (alu_y[3] != a_r[7]);
        end
    end

    // Request capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= 8'h00;
            b_r   <= 8'h00;
            op_r  <= 3'd0;
            cin_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_valid) begin
            a_r   <= op_a;
            b_r   <= op_b;
            op_r  <= op;
            cin_r <= cin;
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            op_r  <= op_r;
            cin_r <= cin_r;
        end
    end

    // Result and flag capture across the two passes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= 8'h00;
            carry_r  <= 1'b0;
            res_cout <= 1'b0;
            res_zero <= 1'b0;
            res_ovf  <= 1'b0;
        end else if (state_r == ST_LO) begin
            result[3:0] <= alu_y;
            carry_r     <= alu_cout;
        end else if (state_r == ST_HI) begin
            result[7:4] <= alu_y;
            res_cout    <= is_logic_s ? 1'b0 : alu_cout;
            res_zero    <= ({alu_y, result[3:0]} == 8'h00);
            res_ovf     <= ovf_s;
        end else begin
            result   <= result;
            carry_r  <= carry_r;
            res_cout <= res_cout;
            res_zero <= res_zero;
            res_ovf  <= res_ovf;
        end
    end

    // Completed-operation counter, stepped on each result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'h0000;
        end else if ((state_r == ST_DONE) && res_ready) begin
            op_count <= op_count + 16'h0001;
        end else begin
            op_count <= op_count;
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomized scoreboard bench for alu_nibble_sequencer with an in-bench 4-bit ALU.
// Inputs change 1-2 time units after rising edges; the monitor samples on falling edges.
module tb_alu_nibble_sequencer;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [2:0]  op;
    logic        cin;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_carry;
    logic [4:0]  alu_s;
    logic [3:0]  alu_y;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  result;
    logic        res_cout;
    logic        res_zero;
    logic        res_ovf;
    logic [15:0] op_count;

    exp_t        q[$];
    int          n_vec;
    int          n_err;
    int          exp_cnt;
    logic        rand_mode;
    logic        fixed_ready;

    alu_nibble_sequencer dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .op(op), .cin(cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry(alu_carry), .alu_s(alu_s),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .res_cout(res_cout), .res_zero(res_zero), .res_ovf(res_ovf),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit ALU: add, add-inverted, and AND/OR/XOR/NOT-a logic (carry-out forced high on logic ops).
    always_comb begin
        logic [4:0] t;
        t        = 5'd0;
        alu_y    = 4'h0;
        alu_cout = 1'b0;
        if (alu_s == 5'b00000) begin
            t = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_carry};
            alu_y = t[3:0]; alu_cout = t[4];
        end else if (alu_s == 5'b00001) begin
            t = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_carry};
            alu_y = t[3:0]; alu_cout = t[4];
        end else if (alu_s[4] && (alu_s[1:0] == 2'b00)) begin
            alu_cout = 1'b1;
            case (alu_s[3:2])
                2'b00:   alu_y = alu_a & alu_b;
                2'b01:   alu_y = alu_a | alu_b;
                2'b10:   alu_y = alu_a ^ alu_b;
                default: alu_y = ~alu_a;
            endcase
        end else begin
            alu_y = 4'h0;
        end
    end

    function automatic exp_t ref_model(logic [7:0] a, logic [7:0] b, logic [2:0] o, logic ci);
        exp_t e;
        int ua, ub, sa, sb, ur, sr, k;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        e = '0;
        if (o[2]) begin
            case (o[1:0])
                2'b00:   e.r = a & b;
                2'b01:   e.r = a | b;
                2'b10:   e.r = a ^ b;
                default: e.r = ~a;
            endcase
        end else begin
            if (o[1]) begin
                k = (o[0] && !ci) ? 1 : 0;          // borrow
                ur = ua - ub - k; sr = sa - sb - k;
                e.c = (ur >= 0);
            end else begin
                k = (o[0] && ci) ? 1 : 0;           // carry
                ur = ua + ub + k; sr = sa + sb + k;
                e.c = (ur > 255);
            end
            e.r = 8'(ur);
            e.v = (sr > 127) || (sr < -128);
        end
        e.z = (e.r == 8'h00);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result-side ready: random or a fixed level, applied 2 units after each rising edge.
    always @(posedge clk) begin
        #2;
        res_ready = rand_mode ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    // Scoreboard monitor: every result handshake pops one expectation.
    always @(negedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            exp_cnt = 0;
        end else if (res_valid && res_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'(res_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("result",   32'(result),   32'(e.r));
                check("res_cout", 32'(res_cout), 32'(e.c));
                check("res_zero", 32'(res_zero), 32'(e.z));
                check("res_ovf",  32'(res_ovf),  32'(e.v));
                check("op_count", 32'(op_count), 32'(exp_cnt[15:0]));
            end
            exp_cnt++;
        end
    end

    // Present a request and hold it until accepted; returns 1 unit after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input bit push);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        op = o; op_a = a; op_b = b; cin = ci; start_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (start_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        start_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; op = $urandom; cin = $urandom;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        else if (push) q.push_back(ref_model(a, b, o, ci));
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (res_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [7:0] r, input logic c,
                              input logic z, input logic v);
        wait_valid();
        check({tag, "_result"}, 32'(result),   32'(r));
        check({tag, "_cout"},   32'(res_cout), 32'(c));
        check({tag, "_zero"},   32'(res_zero), 32'(z));
        check({tag, "_ovf"},    32'(res_ovf),  32'(v));
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (q.size() != 0 || res_valid); i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hold_r;
        logic [3:0] hold_f;
        logic [15:0] hold_cnt;
        n_vec = 0; n_err = 0;
        rand_mode = 1'b0; fixed_ready = 1'b1; res_ready = 1'b1;
        start_valid = 1'b0; op = 3'd0; op_a = 8'h00; op_b = 8'h00; cin = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_res_valid",   32'(res_valid),   32'd0);
        check("rst_result",      32'(result),      32'd0);
        check("rst_flags",       32'({res_cout, res_zero, res_ovf}), 32'd0);
        check("rst_op_count",    32'(op_count),    32'd0);
        check("rst_alu_s",       32'(alu_s),       32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD with latency check: DONE is entered on the third edge counting the accepting edge.
        issue(3'd0, 8'h3C, 8'h45, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("lat_not_yet", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(res_valid), 32'd1);
        expect_res("add", 8'h81, 1'b0, 1'b0, 1'b1);

        issue(3'd2, 8'h10, 8'h01, 1'b0, 1'b1);
        expect_res("sub", 8'h0F, 1'b1, 1'b0, 1'b0);
        issue(3'd2, 8'h55, 8'h55, 1'b0, 1'b1);
        expect_res("sub_zero", 8'h00, 1'b1, 1'b1, 1'b0);

        // ADC: the low-nibble carry must reach the high pass.
        issue(3'd1, 8'hFF, 8'h00, 1'b1, 1'b1);
        check("adc_lo_carry", 32'(alu_carry), 32'd1);
        @(posedge clk); #1;
        check("adc_hi_carry", 32'(alu_carry), 32'd1);
        check("adc_hi_a",     32'(alu_a),     32'hF);
        expect_res("adc", 8'h00, 1'b1, 1'b1, 1'b0);

        issue(3'd5, 8'hA5, 8'h0F, 1'b0, 1'b1);
        check("logic_lo_s", 32'(alu_s), 32'h14);
        @(posedge clk); #1;
        check("logic_hi_s", 32'(alu_s), 32'h14);
        expect_res("logic", 8'hAF, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure: DONE holds with stable outputs until res_ready.
        fixed_ready = 1'b0;
        @(posedge clk); #1;
        issue(3'd3, 8'h23, 8'h47, 1'b0, 1'b1);
        wait_valid();
        hold_r = result;
        hold_f = {res_cout, res_zero, res_ovf, start_ready};
        hold_cnt = op_count;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_result", 32'(result), 32'(hold_r));
            check("bp_flags",  32'({res_cout, res_zero, res_ovf, start_ready}), 32'(hold_f));
            check("bp_count",  32'(op_count), 32'(hold_cnt));
            check("bp_valid",  32'(res_valid), 32'd1);
        end
        check("bp_start_ready", 32'(start_ready), 32'd0);
        fixed_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_count_inc", 32'(op_count), 32'(hold_cnt + 16'd1));
        check("bp_idle",      32'(start_ready), 32'd1);

        // Reset in the high pass aborts the operation.
        issue(3'd2, 8'h80, 8'h01, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_valid",    32'(res_valid),   32'd0);
        check("abort_ready",    32'(start_ready), 32'd1);
        check("abort_result",   32'(result),      32'd0);
        check("abort_flags",    32'({res_cout, res_zero, res_ovf}), 32'd0);
        check("abort_count",    32'(op_count),    32'd0);
        check("abort_alu",      32'({alu_a, alu_b, alu_carry, alu_s}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(res_valid), 32'd0);
        end
        issue(3'd0, 8'h01, 8'h01, 1'b0, 1'b1);
        expect_res("post_rst", 8'h02, 1'b0, 1'b0, 1'b0);
        drain();

        // Randomized traffic with random result backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 80; n++) begin
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
